// File: rtl/framebuffer_write_framer.sv
// framebuffer_write_framer
//   Turns the UART byte stream into framebuffer RAM writes (port A) and panel
//   control register updates. Packets:
//     'L' row, 128 payload bytes [, checksum]  -> RAM writes at {row, byte_idx}
//     'B' mask                                 -> brightness_enable <= mask[5:0]
//     'R' mask                                 -> rgb_enable        <= mask[2:0]
//   Optional build macro FRAMER_CHECKSUM_EN: row packets carry a trailing byte
//   equal to the XOR of the payload, checked in the CHECK state.
// Ports:
//   clk_in, reset_n (async, active-low)
//   rx_data/rx_valid            : received byte + single-cycle strobe
//   ram_data_out/ram_address/
//   ram_write_enable/ram_clk_enable : RAM port A write side
//   brightness_enable, rgb_enable   : panel control registers
//   row_done (pulse), busy, cmd_count (wraps), error_count (saturates)
module framebuffer_write_framer #(
   parameter int                       ROW_BYTES      = 128,
   parameter int                       ROW_ADDR_WIDTH = 5,
   parameter int                       TIMEOUT_WIDTH  = 16,
   parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS  = 16'd4000
) (
   input  logic                                        clk_in,
   input  logic                                        reset_n,
   input  logic [7:0]                                  rx_data,
   input  logic                                        rx_valid,
   output logic [7:0]                                  ram_data_out,
   output logic [ROW_ADDR_WIDTH+$clog2(ROW_BYTES)-1:0] ram_address,
   output logic                                        ram_write_enable,
   output logic                                        ram_clk_enable,
   output logic [5:0]                                  brightness_enable,
   output logic [2:0]                                  rgb_enable,
   output logic                                        row_done,
   output logic                                        busy,
   output logic [7:0]                                  cmd_count,
   output logic [7:0]                                  error_count
);

   localparam int                IDX_W    = $clog2(ROW_BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROW_BYTES - 1);
   localparam logic [7:0]        CMD_ROW  = 8'h4C;
   localparam logic [7:0]        CMD_BRT  = 8'h42;
   localparam logic [7:0]        CMD_RGB  = 8'h52;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ROW     = 3'd1,
      PAYLOAD = 3'd2,
      BRIGHT  = 3'd3,
      RGBEN   = 3'd4
`ifdef FRAMER_CHECKSUM_EN
      ,CHECK  = 3'd5
`endif
   } state_t;

   state_t                      state, state_nxt;
   logic [ROW_ADDR_WIDTH-1:0]   row_q, row_nxt;
   logic [IDX_W-1:0]            byte_idx, idx_nxt;
   logic [TIMEOUT_WIDTH-1:0]    tmo_cnt;
   logic                        timeout;
   logic [7:0]                  wdata_nxt;
   logic [ROW_ADDR_WIDTH+IDX_W-1:0] addr_nxt;
   logic                        we_nxt, done_nxt, cmd_inc, err_inc;
   logic [5:0]                  bright_nxt;
   logic [2:0]                  rgb_nxt;
`ifdef FRAMER_CHECKSUM_EN
   logic [7:0]                  csum, csum_nxt;
`endif

   // A byte on the timeout cycle takes priority, so timeout requires !rx_valid.
   assign timeout = (state != IDLE) && !rx_valid && (tmo_cnt == TIMEOUT_TICKS);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) tmo_cnt <= '0;
      else if (rx_valid || state == IDLE) tmo_cnt <= '0;
      else if (tmo_cnt != TIMEOUT_TICKS) tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
   end

   // State register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (rx_valid) begin
         unique case (state)
            IDLE: begin
               if      (rx_data == CMD_ROW) state_nxt = ROW;
               else if (rx_data == CMD_BRT) state_nxt = BRIGHT;
               else if (rx_data == CMD_RGB) state_nxt = RGBEN;
            end
            ROW:     state_nxt = (rx_data[7:ROW_ADDR_WIDTH] != '0) ? IDLE : PAYLOAD;
`ifdef FRAMER_CHECKSUM_EN
            PAYLOAD: if (byte_idx == LAST_IDX) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
`else
            PAYLOAD: if (byte_idx == LAST_IDX) state_nxt = IDLE;
`endif
            BRIGHT:  state_nxt = IDLE;
            RGBEN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
      end
   end

   // Output / datapath next values; everything is registered below.
   always_comb begin
      row_nxt    = row_q;
      idx_nxt    = byte_idx;
      wdata_nxt  = ram_data_out;
      addr_nxt   = ram_address;
      we_nxt     = 1'b0;
      done_nxt   = 1'b0;
      cmd_inc    = 1'b0;
      err_inc    = 1'b0;
      bright_nxt = brightness_enable;
      rgb_nxt    = rgb_enable;
`ifdef FRAMER_CHECKSUM_EN
      csum_nxt   = csum;
`endif
      if (rx_valid) begin
         unique case (state)
            IDLE: begin
               if (rx_data != CMD_ROW && rx_data != CMD_BRT && rx_data != CMD_RGB)
                  err_inc = 1'b1;
            end
            ROW: begin
               if (rx_data[7:ROW_ADDR_WIDTH] != '0) begin
                  err_inc = 1'b1;
               end else begin
                  row_nxt = rx_data[ROW_ADDR_WIDTH-1:0];
                  idx_nxt = '0;
`ifdef FRAMER_CHECKSUM_EN
                  csum_nxt = '0;
`endif
               end
            end
            PAYLOAD: begin
               we_nxt    = 1'b1;
               wdata_nxt = rx_data;
               addr_nxt  = {row_q, byte_idx};
               idx_nxt   = byte_idx + IDX_W'(1);
`ifdef FRAMER_CHECKSUM_EN
               csum_nxt  = csum ^ rx_data;
`else
               if (byte_idx == LAST_IDX) begin
                  done_nxt = 1'b1;
                  cmd_inc  = 1'b1;
               end
`endif
            end
`ifdef FRAMER_CHECKSUM_EN
            CHECK: begin
               if (rx_data == csum) begin
                  done_nxt = 1'b1;
                  cmd_inc  = 1'b1;
               end else begin
                  err_inc  = 1'b1;
               end
            end
`endif
            BRIGHT: begin
               bright_nxt = rx_data[5:0];
               cmd_inc    = 1'b1;
            end
            RGBEN: begin
               rgb_nxt = rx_data[2:0];
               cmd_inc = 1'b1;
            end
            default: ;
         endcase
      end else if (timeout) begin
         err_inc = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         row_q             <= '0;
         byte_idx          <= '0;
         ram_data_out      <= '0;
         ram_address       <= '0;
         ram_write_enable  <= 1'b0;
         ram_clk_enable    <= 1'b0;
         brightness_enable <= 6'h3F;
         rgb_enable        <= 3'b111;
         row_done          <= 1'b0;
         busy              <= 1'b0;
         cmd_count         <= '0;
         error_count       <= '0;
`ifdef FRAMER_CHECKSUM_EN
         csum              <= '0;
`endif
      end else begin
         row_q             <= row_nxt;
         byte_idx          <= idx_nxt;
         ram_data_out      <= wdata_nxt;
         ram_address       <= addr_nxt;
         ram_write_enable  <= we_nxt;
         ram_clk_enable    <= we_nxt;
         brightness_enable <= bright_nxt;
         rgb_enable        <= rgb_nxt;
         row_done          <= done_nxt;
         busy              <= (state_nxt != IDLE);
         if (cmd_inc) cmd_count <= cmd_count + 8'd1;
         if (err_inc && error_count != 8'hFF) error_count <= error_count + 8'd1;
`ifdef FRAMER_CHECKSUM_EN
         csum              <= csum_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_framebuffer_write_framer.sv
// Directed bench for framebuffer_write_framer (default TIMEOUT_TICKS = 4000).
module tb_framebuffer_write_framer;

   localparam int TICKS = 4000;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  ram_data_out;
   logic [11:0] ram_address;
   logic        ram_write_enable, ram_clk_enable;
   logic [5:0]  brightness_enable;
   logic [2:0]  rgb_enable;
   logic        row_done, busy;
   logic [7:0]  cmd_count, error_count;

   int checks = 0;
   int failures = 0;

   logic [11:0] wq_addr[$];
   logic [7:0]  wq_data[$];
   int          rd_cnt = 0;
   int          ce_bad = 0;

   framebuffer_write_framer dut (
      .clk_in(clk_in), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .ram_data_out(ram_data_out), .ram_address(ram_address),
      .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable),
      .brightness_enable(brightness_enable), .rgb_enable(rgb_enable),
      .row_done(row_done), .busy(busy), .cmd_count(cmd_count), .error_count(error_count)
   );

   always #5 clk_in = ~clk_in;

   // Record every write cycle and row_done cycle, sampled mid-cycle.
   always @(negedge clk_in) begin
      if (reset_n) begin
         if (ram_write_enable) begin
            wq_addr.push_back(ram_address);
            wq_data.push_back(ram_data_out);
         end
         if (ram_clk_enable !== ram_write_enable) ce_bad++;
         if (row_done) rd_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      wq_addr.delete();
      wq_data.delete();
      rd_cnt = 0;
      ce_bad = 0;
   endtask

   // One byte strobe followed by one idle cycle with junk on rx_data.
   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk_in); #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(posedge clk_in); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Writes must be n entries at base+i carrying data i.
   task automatic check_writes(input string tag, input logic [11:0] base, input int n);
      int bad;
      bad = 0;
      chk({tag, "_nwr"}, wq_addr.size(), n);
      for (int i = 0; i < wq_addr.size(); i++)
         if (wq_addr[i] !== base + 12'(i) || wq_data[i] !== 8'(i)) bad++;
      chk({tag, "_wr_bad"}, bad, 0);
      chk({tag, "_ce_bad"}, ce_bad, 0);
   endtask

   initial begin
      // Reset
      idle(3);
      chk("rst_bright", brightness_enable, 6'h3F);
      chk("rst_rgb", rgb_enable, 3'b111);
      chk("rst_busy", busy, 0);
      chk("rst_cmd", cmd_count, 0);
      chk("rst_err", error_count, 0);
      chk("rst_we", ram_write_enable, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_done", row_done, 0);
      #2 reset_n = 1'b1;
      idle(2);

      // Row 5 load
      clr_mon();
      send(8'h4C);
      send(8'h05);
      chk("row_busy", busy, 1);
      rx_data = 8'h00; rx_valid = 1'b1;
      @(posedge clk_in); #1;
      rx_valid = 1'b0;
      chk("row_lat_we", ram_write_enable, 1);
      chk("row_lat_addr", ram_address, 12'h280);
      chk("row_lat_data", ram_data_out, 8'h00);
      @(posedge clk_in); #1;
      chk("row_pulse_we", ram_write_enable, 0);
      for (int i = 1; i < 128; i++) send(8'(i));
`ifdef FRAMER_CHECKSUM_EN
      send(8'h00);
`endif
      check_writes("row5", 12'h280, 128);
      chk("row5_done", rd_cnt, 1);
      chk("row5_cmd", cmd_count, 1);
      chk("row5_err", error_count, 0);
      chk("row5_busy", busy, 0);

      // Brightness / RGB enable
      send(8'h42); send(8'hC3);
      chk("bright_val", brightness_enable, 6'h03);
      chk("bright_cmd", cmd_count, 2);
      send(8'h52); send(8'h05);
      chk("rgb_val", rgb_enable, 3'b101);
      chk("rgb_cmd", cmd_count, 3);

      // Bad row index and unknown command
      clr_mon();
      send(8'h4C); send(8'h20);
      chk("badrow_err", error_count, 1);
      chk("badrow_busy", busy, 0);
      chk("badrow_nwr", wq_addr.size(), 0);
      chk("badrow_cmd", cmd_count, 3);
      send(8'h5A);
      chk("unk_err", error_count, 2);

      // Inter-byte timeout mid-row
      clr_mon();
      send(8'h4C); send(8'h00);
      for (int i = 0; i < 10; i++) send(8'(i));
      idle(TICKS - 1);
      chk("tmo_pre_busy", busy, 1);
      chk("tmo_pre_err", error_count, 2);
      idle(1);
      chk("tmo_busy", busy, 0);
      chk("tmo_err", error_count, 3);
      check_writes("tmo", 12'h000, 10);
      chk("tmo_done", rd_cnt, 0);
      send(8'h42); send(8'h3F);
      chk("tmo_after_bright", brightness_enable, 6'h3F);
      chk("tmo_after_cmd", cmd_count, 4);

      // Byte lands exactly on the timeout cycle: processed
      send(8'h42);
      idle(TICKS - 1);
      chk("edge_busy", busy, 1);
      send(8'h15);
      chk("edge_bright", brightness_enable, 6'h15);
      chk("edge_err", error_count, 3);
      chk("edge_cmd", cmd_count, 5);
      chk("edge_busy_after", busy, 0);

`ifdef FRAMER_CHECKSUM_EN
      // Wrong checksum: all writes happen, no row_done
      clr_mon();
      send(8'h4C); send(8'h01);
      for (int i = 0; i < 128; i++) send(8'(i));
      send(8'hFF);
      check_writes("csum", 12'h080, 128);
      chk("csum_done", rd_cnt, 0);
      chk("csum_err", error_count, 4);
      chk("csum_cmd", cmd_count, 5);
`endif

      // cmd_count wraps 255 -> 0
      for (int i = 0; i < 251; i++) begin send(8'h52); send(8'h07); end
      chk("wrap_cmd", cmd_count, 0);
      chk("wrap_rgb", rgb_enable, 3'b111);

      // error_count saturates at 255
      for (int i = 0; i < 260; i++) send(8'h5A);
      chk("sat_err", error_count, 8'hFF);
      chk("sat_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
